dcim_product_accumulator: RTL and testbench
===========================================

// Module: dcim_product_accumulator
// PURPOSE
//  Downstream stage of the SRAM/log-multiplier DCIM macro. Consumes the 64-bit
//  product stream (one product per SRAM address per cycle) and sums it over a
//  window of ACC_LEN products, i.e. one dot product per pass over the array.
//  Completed sums are queued in a small output FIFO with a valid/ready handshake.
//  Because the upstream stage cannot be stalled, a full FIFO drops results and
//  flags the loss.
// PARAMETERS
//  PROD_WIDTH  64  width of incoming product (unsigned)
//  ACC_LEN     64  products per window (>=2)
//  CNT_WIDTH   6   window counter width, = clog2(ACC_LEN)
//  ACC_WIDTH   72  accumulator/result width, >= PROD_WIDTH+CNT_WIDTH, no overflow
//  FIFO_DEPTH  2   result FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1           clock, all state on posedge
//  rst_n      in   1           asynchronous active-low reset
//  en         in   1           stage enable (tie to upstream init_done); 0 ignores prod_valid
//  clr        in   1           synchronous clear of acc, counter, FIFO, ovf
//  prod_in    in   PROD_WIDTH  product from multiplier stage (upstream data_out)
//  prod_valid in   1           product qualifier (upstream valid_out)
//  res_data   out  ACC_WIDTH   FIFO head: completed window sum
//  res_valid  out  1           FIFO non-empty
//  res_ready  in   1           consumer accepts head when res_valid&res_ready
//  win_cnt    out  CNT_WIDTH   products accumulated in current window
//  busy       out  1           FSM in ACCUM
//  ovf        out  1           sticky: a completed result was dropped
// BEHAVIOUR
//  - Reset (rst_n=0, async): acc=0, win_cnt=0, FIFO empty, res_valid=0,
//    res_data=0, ovf=0, busy=0, FSM=IDLE. Reset mid-window discards partial sum.
//  - accept = en & prod_valid & ~clr. prod_in is zero-extended to ACC_WIDTH.
//  - FSM IDLE: on accept -> ACCUM, acc<=prod_in, win_cnt<=1.
//    FSM ACCUM: on accept, acc<=acc+prod_in, win_cnt<=win_cnt+1.
//    If accept while win_cnt==ACC_LEN-1: push acc+prod_in into the FIFO,
//    acc<=0, win_cnt<=0, -> IDLE. Back-to-back windows run with no bubble:
//    a product accepted in IDLE starts the next window.
//  - en=0 or prod_valid=0: acc/win_cnt hold (partial window preserved).
//  - Latency: sum is visible on res_data with res_valid=1 the cycle after the
//    edge that accepted the last product (1 cycle), if the FIFO was empty.
//  - FIFO: pop on res_valid&res_ready. res_data is stable while res_valid&~res_ready.
//    Push+pop same cycle when full: both occur, no drop. Push when full without
//    pop: result dropped, FIFO unchanged, ovf<=1 (sticky until clr/reset).
//    Pop when empty: ignored.
//  - clr=1: next edge acc=0, win_cnt=0, FIFO empty, ovf=0, FSM=IDLE; clr
//    overrides a simultaneous accept/push/pop.
//  - Addition never wraps at default widths (64*(2^64-1) < 2^72).
//  - busy = (FSM==ACCUM).
// TESTING
//  1 ACC_LEN=64, prod_in=1..64 consecutive, res_ready=1 -> one res_valid pulse
//    with res_data=2080, one cycle after the 64th product; win_cnt back to 0.
//  2 64 products of 2^64-1 -> res_data=0x3F_FFFF_FFFF_FFFF_FFC0 (no wrap).
//  3 prod_valid toggled 1/0 and en low for 10 cycles mid-window -> same sum as
//    test 1; win_cnt holds while idle.
//  4 res_ready=0, three full windows (sums 64,128,192 with constant prod 1,2,3)
//    -> FIFO holds 64,128; third dropped, ovf=1; then ready=1 drains 64 then 128.
//  5 FIFO full, window completes same cycle res_ready=1 -> no drop, ovf stays 0.
//  6 rst_n low at win_cnt=30 (async, between edges) -> all outputs 0 immediately;
//    after release, a fresh 64-product window sums correctly; clr gives same
//    result synchronously.

Source files
------------

// File: rtl/dcim_product_accumulator.sv
// Sums the DCIM product stream over ACC_LEN-product windows and queues each completed
// dot product in a small valid/ready result FIFO; results that find the FIFO full are dropped.
module dcim_product_accumulator #(
    parameter int PROD_WIDTH = 64,
    parameter int ACC_LEN    = 64,
    parameter int CNT_WIDTH  = 6,
    parameter int ACC_WIDTH  = 72,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PROD_WIDTH-1:0] prod_in,
    input  logic                  prod_valid,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CNT_WIDTH-1:0]  win_cnt,
    output logic                  busy,
    output logic                  ovf
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);
    localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   sum;
    logic [ACC_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH:0]     fill;
    logic                   accept;
    logic                   last;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   do_push;

    assign prod_ext  = ACC_WIDTH'(prod_in);
    assign sum       = acc + prod_ext;
    assign accept    = en & prod_valid & ~clr;
    assign last      = (state == ACCUM) && (win_cnt == LAST_CNT);
    assign push      = accept & last;
    assign res_valid = (fill != '0);
    assign pop       = res_valid & res_ready;
    assign full      = (fill == FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO only drops when nobody reads.
    assign do_push   = push & (~full | pop);
    assign res_data  = res_valid ? mem[rd_ptr] : '0;
    assign busy      = (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            win_cnt <= '0;
            ovf     <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
        end else if (clr) begin
            state   <= IDLE;
            acc     <= '0;
            win_cnt <= '0;
            ovf     <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
        end else begin
            if (accept) begin
                case (state)
                    IDLE: begin
                        state   <= ACCUM;
                        acc     <= prod_ext;
                        win_cnt <= CNT_WIDTH'(1);
                    end
                    ACCUM: begin
                        if (last) begin
                            state   <= IDLE;
                            acc     <= '0;
                            win_cnt <= '0;
                        end else begin
                            acc     <= sum;
                            win_cnt <= win_cnt + CNT_WIDTH'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (push && !do_push) begin
                ovf <= 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({do_push, pop})
                2'b10:   fill <= fill + (PTR_WIDTH + 1)'(1);
                2'b01:   fill <= fill - (PTR_WIDTH + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Storage needs no reset; res_data is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= sum;
        end
    end

endmodule

// File: tb/tb_dcim_product_accumulator.sv
// Bench for dcim_product_accumulator: directed windows, a small vector table and a
// randomized run, all compared every cycle against a queue-based window/FIFO model.
module tb_dcim_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [63:0] prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [71:0] res_data;
    logic        res_valid;
    logic [5:0]  win_cnt;
    logic        busy;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    logic [71:0] m_acc;
    int          m_cnt;
    logic [71:0] m_fifo[$];
    logic        m_ovf;

    typedef struct {
        logic        clr;
        logic        en;
        logic        pv;
        logic [63:0] prod;
        logic        rdy;
        int          exp_cnt;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[8];

    dcim_product_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .win_cnt    (win_cnt),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_cnt = 0;
        m_fifo.delete();
        m_ovf = 1'b0;
    endtask

    // Window = ACC_LEN accepted products; FIFO holds at most two sums, head pops before tail pushes.
    task automatic model_step();
        bit          pop_now;
        bit          pushing;
        logic [71:0] done_sum;
        if (clr) begin
            model_reset();
            return;
        end
        pop_now = (m_fifo.size() > 0) && res_ready;
        pushing = 1'b0;
        done_sum = '0;
        if (en && prod_valid) begin
            m_acc = m_acc + {8'h00, prod_in};
            m_cnt++;
            if (m_cnt == 64) begin
                pushing = 1'b1;
                done_sum = m_acc;
                m_acc = '0;
                m_cnt = 0;
            end
        end
        if (pop_now) void'(m_fifo.pop_front());
        if (pushing) begin
            if (m_fifo.size() < 2) m_fifo.push_back(done_sum);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_output();
        check_val("res_valid", {71'd0, res_valid}, {71'd0, m_fifo.size() > 0});
        check_val("res_data", res_data, (m_fifo.size() > 0) ? m_fifo[0] : 72'd0);
        check_val("win_cnt", {66'd0, win_cnt}, 72'(m_cnt));
        check_val("busy", {71'd0, busy}, {71'd0, m_cnt != 0});
        check_val("ovf", {71'd0, ovf}, {71'd0, m_ovf});
    endtask

    task automatic apply_stimulus(input logic c, input logic e, input logic v,
                                  input logic [63:0] p, input logic r);
        clr = c;
        en = e;
        prod_valid = v;
        prod_in = p;
        res_ready = r;
        model_step();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic run_window(input logic [63:0] p, input logic r);
        for (int i = 0; i < 64; i++) apply_stimulus(1'b0, 1'b1, 1'b1, p, r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, {71'd0, res_valid}, 72'd0);
        check_val({tag, "_data"}, res_data, 72'd0);
        check_val({tag, "_cnt"}, {66'd0, win_cnt}, 72'd0);
        check_val({tag, "_busy"}, {71'd0, busy}, 72'd0);
        check_val({tag, "_ovf"}, {71'd0, ovf}, 72'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 64'd9, 1'b1, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 64'd5, 1'b1, 1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 64'd7, 1'b1, 1, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 64'd9, 1'b1, 1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 64'd10, 1'b1, 2, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 64'd0, 1'b0, 3, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 64'd4, 1'b1, 0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 64'd3, 1'b1, 1, 1'b1};

        model_reset();
        #12;
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Consecutive 1..64 gives the triangular sum one cycle after the last product.
        for (int i = 1; i <= 64; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 64'(i), 1'b1);
        check_val("t1_sum", res_data, 72'd2080);
        check_val("t1_valid", {71'd0, res_valid}, 72'd1);
        check_val("t1_cnt", {66'd0, win_cnt}, 72'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
        check_val("t1_pulse_end", {71'd0, res_valid}, 72'd0);

        run_window(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check_val("t2_nowrap", res_data, 72'h3F_FFFF_FFFF_FFFF_FFC0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);

        for (int i = 1; i <= 64; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b1, 64'(i), 1'b1);
            apply_stimulus(1'b0, 1'b1, 1'b0, 64'hDEAD, 1'b1);
            if (i == 20) begin
                for (int k = 0; k < 10; k++) apply_stimulus(1'b0, 1'b0, 1'b1, 64'hBEEF, 1'b1);
                check_val("t3_hold_cnt", {66'd0, win_cnt}, 72'd20);
            end
        end
        check_val("t3_sum", res_data, 72'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].clr, vecs[i].en, vecs[i].pv, vecs[i].prod, vecs[i].rdy);
            check_val($sformatf("vec%0d_cnt", i), {66'd0, win_cnt}, 72'(vecs[i].exp_cnt));
            check_val($sformatf("vec%0d_busy", i), {71'd0, busy}, {71'd0, vecs[i].exp_busy});
        end

        apply_stimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        run_window(64'd1, 1'b0);
        run_window(64'd2, 1'b0);
        run_window(64'd3, 1'b0);
        check_val("t4_ovf", {71'd0, ovf}, 72'd1);
        check_val("t4_head", res_data, 72'd64);
        apply_stimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        check_val("t4_second", res_data, 72'd128);
        check_val("t4_second_valid", {71'd0, res_valid}, 72'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        check_val("t4_drained", {71'd0, res_valid}, 72'd0);

        apply_stimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        run_window(64'd1, 1'b0);
        run_window(64'd2, 1'b0);
        for (int i = 0; i < 63; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 64'd3, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 64'd3, 1'b1);
        check_val("t5_ovf", {71'd0, ovf}, 72'd0);
        check_val("t5_head", res_data, 72'd128);
        apply_stimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        check_val("t5_tail", res_data, 72'd192);
        apply_stimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);

        // Asynchronous reset mid-window, asserted between clock edges.
        for (int i = 0; i < 30; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 64'(i + 7), 1'b0);
        check_val("t6_cnt30", {66'd0, win_cnt}, 72'd30);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_async");
        model_reset();
        en = 1'b0;
        prod_valid = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 64; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 64'(i), 1'b1);
        check_val("t6_fresh", res_data, 72'd2080);
        for (int i = 0; i < 30; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 64'(i + 7), 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 64'd99, 1'b0);
        check_reset_outputs("t6_clr");
        for (int i = 1; i <= 64; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 64'(i), 1'b1);
        check_val("t6_clr_fresh", res_data, 72'd2080);

        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                           $urandom_range(0, 3) != 0, {$urandom, $urandom},
                           $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
